pulse_train_gen: RTL

Programmable pulse-train generator for the Camera Link timing generator; the transmit-side counterpart of the edge detector. A trigger starts a waveform. Each waveform is an initial delay followed by a fixed number of high/low pulses, or a continuous train. The block drives `sig_out` with registered, glitch-free levels. It also emits `rise` and `fall` pulses coincident with its own transitions, so downstream logic (exposure/strobe control) sees the same edge events a receiver-side detector would report.

---
 rtl/cmlk_timing_pkg.sv | 15 +
 rtl/phase_counter.sv | 27 ++
 rtl/pulse_train_gen.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/cmlk_timing_pkg.sv
// Shared Camera Link timing definitions: default counter widths and the
// generator state encoding used by the timing blocks.
package cmlk_timing_pkg;

    localparam int unsigned DefCntW = 16;
    localparam int unsigned DefNumW = 8;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StDelay = 2'd1,
        StHigh  = 2'd2,
        StLow   = 2'd3
    } timing_state_e;

endpackage

// File: rtl/phase_counter.sv
// Loadable down-counter timing a single waveform phase; zero marks the
// final cycle of the phase that was loaded.
module phase_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/pulse_train_gen.sv
// Programmable pulse-train generator: trigger, initial delay, then counted
// or continuous high/low pulses with registered level and edge outputs.
module pulse_train_gen
    import cmlk_timing_pkg::*;
#(
    parameter int unsigned CNT_W = DefCntW,
    parameter int unsigned NUM_W = DefNumW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trig,
    input  logic             abort,
    input  logic [CNT_W-1:0] cfg_delay,
    input  logic [CNT_W-1:0] cfg_high,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [NUM_W-1:0] cfg_count,
    output logic             sig_out,
    output logic             rise,
    output logic             fall,
    output logic             busy,
    output logic             done
);

    timing_state_e    state_q, state_d;
    logic [CNT_W-1:0] hi_q, lo_q;
    logic [NUM_W-1:0] count_q, pcnt_q, pcnt_d;
    logic             sig_q, rise_q, fall_q, busy_q, done_q;

    logic [CNT_W-1:0] hi_in, hi_p1, per_in, lo_in;
    logic             accept, done_d, load, zero;
    logic [CNT_W-1:0] load_val;

    // Effective phase lengths derived from the raw configuration inputs.
    always_comb begin
        hi_in  = (cfg_high == '0) ? CNT_W'(1) : cfg_high;
        hi_p1  = (&hi_in) ? hi_in : hi_in + CNT_W'(1);
        per_in = (cfg_period > hi_p1) ? cfg_period : hi_p1;
        lo_in  = per_in - hi_in;
        if (lo_in == '0) begin
            lo_in = CNT_W'(1);
        end
    end

    phase_counter #(
        .CNT_W(CNT_W)
    ) u_phase_counter (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .load_val(load_val),
        .zero    (zero)
    );

    always_comb begin
        state_d  = state_q;
        pcnt_d   = pcnt_q;
        accept   = 1'b0;
        done_d   = 1'b0;
        load     = 1'b0;
        load_val = '0;
        unique case (state_q)
            StIdle: begin
                if (trig) begin
                    accept = 1'b1;
                    pcnt_d = '0;
                    load   = 1'b1;
                    if (cfg_delay != '0) begin
                        state_d  = StDelay;
                        load_val = cfg_delay - CNT_W'(1);
                    end else begin
                        state_d  = StHigh;
                        load_val = hi_in - CNT_W'(1);
                    end
                end
            end
            StDelay: begin
                if (zero) begin
                    state_d  = StHigh;
                    load     = 1'b1;
                    load_val = hi_q - CNT_W'(1);
                end
            end
            StHigh: begin
                if (zero) begin
                    state_d  = StLow;
                    load     = 1'b1;
                    load_val = lo_q - CNT_W'(1);
                end
            end
            StLow: begin
                if (zero) begin
                    pcnt_d = pcnt_q + NUM_W'(1);
                    if ((count_q != '0) && (pcnt_d == count_q)) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else begin
                        state_d  = StHigh;
                        load     = 1'b1;
                        load_val = hi_q - CNT_W'(1);
                    end
                end
            end
        endcase
        // Abort overrides everything, including a same-cycle trigger.
        if (abort) begin
            state_d = StIdle;
            pcnt_d  = pcnt_q;
            accept  = 1'b0;
            done_d  = 1'b0;
            load    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            hi_q    <= '0;
            lo_q    <= '0;
            count_q <= '0;
            pcnt_q  <= '0;
            sig_q   <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pcnt_q  <= pcnt_d;
            if (accept) begin
                hi_q    <= hi_in;
                lo_q    <= lo_in;
                count_q <= cfg_count;
            end
            // Outputs follow the next state so they line up with the phase itself.
            sig_q  <= (state_d == StHigh);
            rise_q <= (state_d == StHigh) && (state_q != StHigh);
            fall_q <= sig_q && (state_d != StHigh);
            busy_q <= (state_d != StIdle);
            done_q <= done_d;
        end
    end

    assign sig_out = sig_q;
    assign rise    = rise_q;
    assign fall    = fall_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule
